// File: rtl/hybrid_sar_ctrl.sv
// Successive-approximation sequencer for the hybrid analog tile: drives the DAC
// ladder and sample/hold switch, resolving one result bit per SETTLE-cycle phase.
module hybrid_sar_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             cmp,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE) ? SAMPLE_CYCLES : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIDSCALE    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [BIT_W-1:0] bit_idx, bit_next;
  logic [WIDTH-1:0] code, code_next;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] trial_bit;
  logic             cmp_meta, cmp_s;

  // cmp is asynchronous to clk, so it only reaches the decision logic through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      code     <= '0;
      result   <= '0;
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_next;
      code     <= code_next;
      result   <= result_next;
      cmp_meta <= cmp;
      cmp_s    <= cmp_meta;
    end
  end

  assign trial_bit = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bit_next    = bit_idx;
    code_next   = code;
    result_next = result;
    sample      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    dac_code    = '0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = SAMPLE;
          cnt_next   = '0;
        end
      end

      SAMPLE: begin
        sample   = 1'b1;
        busy     = 1'b1;
        dac_code = MIDSCALE;
        if (cnt == SAMPLE_LAST) begin
          state_next = CONVERT;
          cnt_next   = '0;
          bit_next   = MSB_IDX;
          code_next  = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      // code holds only decided bits; the bit under trial is OR'd in for the DAC
      CONVERT: begin
        busy     = 1'b1;
        dac_code = code | trial_bit;
        if (cnt == SETTLE_LAST) begin
          cnt_next = '0;
          if (cmp_s) begin
            code_next = code | trial_bit;
          end
          if (bit_idx == '0) begin
            state_next  = DONE;
            result_next = code_next;
          end else begin
            bit_next = bit_idx - 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        dac_code   = code;
        cnt_next   = '0;
        state_next = cont ? SAMPLE : IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hybrid_sar_ctrl.sv
// Directed bench for hybrid_sar_ctrl: default instance driven by an ideal comparator,
// plus a WIDTH=4 / SETTLE=3 instance for the latency sweep.
module tb_hybrid_sar_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont, cmp;
  logic       sample, busy, done;
  logic [7:0] dac_code, result;

  logic       start2;
  logic       cmp2;
  logic       sample2, busy2, done2;
  logic [3:0] dac2, result2, vin2;

  logic [7:0] vin;
  logic       cmp_noise;
  int         cyc;
  int         e0;
  int         period;
  int         n_compared;
  int         n_mismatched;

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp_result;
    logic       noise;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  hybrid_sar_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cont     (cont),
    .cmp      (cmp),
    .sample   (sample),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  hybrid_sar_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(4), .SETTLE(3)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .cont     (1'b0),
    .cmp      (cmp2),
    .sample   (sample2),
    .dac_code (dac2),
    .busy     (busy2),
    .done     (done2),
    .result   (result2)
  );

  // With SETTLE=3 the trial code is stable a full cycle before cmp is captured
  assign cmp2 = (vin2 >= dac2);

  function automatic logic [7:0] trialCode(input logic [7:0] v, input int k);
    logic [7:0] hi_mask;
    logic [7:0] msb;
    hi_mask = 8'hFF;
    msb     = 8'h80;
    hi_mask = hi_mask << (8 - k);
    return (v & hi_mask) | (msb >> k);
  endfunction

  // With SETTLE=2 the synchronizer captures cmp on the very edge that loads a new
  // trial, so the ideal comparator presents Vin >= trial for that capture edge.
  always @(posedge clk) begin
    int t;
    #2;
    cyc = cyc + 1;
    t = cyc + 1 - e0;
    if (period > 0 && t >= 0) t = t % period;
    if (e0 >= 0 && t >= 4 && t <= 18 && (t % 2) == 0)
      cmp = (vin >= trialCode(vin, (t - 4) / 2));
    else if (cmp_noise)
      cmp = 1'($urandom_range(0, 1));
    else
      cmp = (vin >= dac_code);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] exp_res);
    int first_done;
    first_done = -1;
    @(negedge clk);
    vin    = v;
    period = 0;
    start  = 1'b1;
    e0     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_rise", busy, 1);
    for (int m = 0; m <= 40; m++) begin
      if (m > 0) @(negedge clk);
      if (m == 3) checkOutput("sample_hold", sample, 1);
      if (m == 4) checkOutput("sample_fall", sample, 0);
      if (m >= 4 && m <= 18 && (m % 2) == 0)
        checkOutput("dac_trial", dac_code, trialCode(v, (m - 4) / 2));
      if (first_done >= 0) begin
        checkOutput("done_width", done, 0);
        checkOutput("busy_fall", busy, 0);
        break;
      end
      if (done) begin
        first_done = m;
        checkOutput("result", result, exp_res);
        checkOutput("dac_final", dac_code, exp_res);
      end
    end
    checkOutput("latency", first_done, 20);
  endtask

  task automatic runNarrow(input logic [3:0] v, input logic [3:0] exp_res);
    int first_done;
    first_done = -1;
    @(negedge clk);
    vin2   = v;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int m = 0; m <= 30; m++) begin
      if (m > 0) @(negedge clk);
      if (done2) begin
        first_done = m;
        checkOutput("w4_result", result2, exp_res);
        break;
      end
    end
    checkOutput("w4_latency", first_done, 16);
  endtask

  initial begin
    int n_done, busy_low, d0, done_seen;

    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0};
    vecs[3] = '{8'h5A, 8'h5A, 1'b0};
    vecs[4] = '{8'h01, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0};
    vecs[6] = '{8'hA5, 8'hA5, 1'b1};
    vecs[7] = '{8'h6B, 8'h6B, 1'b1};

    n_compared   = 0;
    n_mismatched = 0;
    cyc       = 0;
    e0        = -1;
    period    = 0;
    vin       = 8'h00;
    vin2      = 4'h0;
    cmp       = 1'b0;
    cmp_noise = 1'b0;
    rst       = 1'b1;
    start     = 1'b1;
    cont      = 1'b1;
    start2    = 1'b1;

    // start/cont held high during reset must not launch a conversion
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {sample, busy, done, dac_code, result}, 0);
    checkOutput("reset_state_w4", {sample2, busy2, done2, dac2, result2}, 0);
    rst    = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", busy, 0);

    for (int i = 0; i < 8; i++) begin
      cmp_noise = vecs[i].noise;
      applyStimulus(vecs[i].vin, vecs[i].exp_result);
    end
    cmp_noise = 1'b0;

    // start held high with cont=0: one idle cycle between conversions
    @(negedge clk);
    vin    = 8'h77;
    period = 22;
    start  = 1'b1;
    e0     = cyc + 1;
    n_done = 0; busy_low = 0; d0 = -1;
    for (int m = 0; m <= 60; m++) begin
      @(negedge clk);
      if (n_done == 1 && !busy) busy_low++;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          d0 = m;
          checkOutput("held_result1", result, 8'h77);
          vin = 8'h3E;
        end else begin
          checkOutput("held_gap", m - d0, 22);
          checkOutput("held_result2", result, 8'h3E);
          start = 1'b0;
          break;
        end
      end
    end
    checkOutput("held_two_done", n_done, 2);
    checkOutput("held_busy_low", busy_low, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("held_idle", busy, 0);

    // continuous mode: back-to-back conversions, Vin stepped between them
    @(negedge clk);
    vin    = 8'h10;
    cont   = 1'b1;
    period = 21;
    start  = 1'b1;
    e0     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; busy_low = 0; d0 = -1;
    for (int m = 0; m <= 60; m++) begin
      if (m > 0) @(negedge clk);
      if (!busy) busy_low++;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          d0 = m;
          checkOutput("cont_result1", result, 8'h10);
          vin = 8'h3C;
        end else begin
          checkOutput("cont_period", m - d0, 21);
          checkOutput("cont_result2", result, 8'h3C);
          cont = 1'b0;
          break;
        end
      end
    end
    checkOutput("cont_two_done", n_done, 2);
    checkOutput("cont_busy_low", busy_low, 0);
    @(negedge clk);
    checkOutput("cont_stop", busy, 0);
    period = 0;

    // reset during the bit-5 phase aborts without a done strobe
    @(negedge clk);
    vin   = 8'hA5;
    start = 1'b1;
    e0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_clear", {sample, busy, done, dac_code, result}, 0);
    rst = 1'b0;
    done_seen = 0;
    for (int m = 0; m < 25; m++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("no_done_after_rst", done_seen, 0);
    checkOutput("idle_after_rst", busy, 0);
    e0 = -1;
    applyStimulus(8'h3C, 8'h3C);

    runNarrow(4'hB, 4'hB);
    runNarrow(4'h0, 4'h0);
    runNarrow(4'hF, 4'hF);
    runNarrow(4'h6, 4'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
